// File: rtl/soc_sram_pkg.sv
// soc_sram_pkg: shared constants and helpers for the SRAM-port responder.
// Holds the register-window select value, register offsets and the LED width.
package soc_sram_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF004;
  localparam logic [15:0] OFF_SWITCH = 16'hF008;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  localparam int LED_W = 16;
  localparam int SW_W  = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_NUM,
    REG_SWITCH,
    REG_TIMER
  } mmio_reg_e;

  // Map a word offset (byte offset bits [15:2]) inside the window to a register.
  function automatic mmio_reg_e decode_offset(input logic [13:0] word_off);
    mmio_reg_e r;
    r = REG_NONE;
    if (word_off == OFF_LED[15:2])         r = REG_LED;
    else if (word_off == OFF_NUM[15:2])    r = REG_NUM;
    else if (word_off == OFF_SWITCH[15:2]) r = REG_SWITCH;
    else if (word_off == OFF_TIMER[15:2])  r = REG_TIMER;
    return r;
  endfunction

  // Replace the byte lanes of old_w selected by be with the lanes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_dp_bytewe.sv
// sram_dp_bytewe: dual-port word RAM. Port A is read-only, port B reads and
// writes with per-byte enables. Both read ports are registered (1-cycle) and
// read-first: a same-edge write never shows through a read of that edge.
// Contents are not reset; only the read registers are.
module sram_dp_bytewe #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_en_i,
  input  logic [DATA_W/8-1:0] b_wen_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic [DATA_W-1:0]   b_rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Registered reads on both ports and byte-lane writes on port B; writes are
  // suppressed while reset is asserted at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i) begin
        b_rdata_q <= mem_q[b_addr_i];
        for (int i = 0; i < NB; i++) begin
          if (b_wen_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/soc_sram_responder.sv
// soc_sram_responder: memory-side target for the CPU instruction and data
// SRAM ports. Shared dual-port RAM plus a register window (LED, NUM, SWITCH,
// TIMER) selected by addr[31:16] == MMIO_HI. One-cycle read latency on both
// ports; rdata holds between enabled accesses.
// Build option: define SOC_SRAM_RESP_TIMER_EN to include the free-running
// TIMER register; without it offset 0xE000 reads 0 and ignores writes.
module soc_sram_responder
  import soc_sram_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  input  logic [7:0]  switch
);

  logic            inst_mmio;
  logic            data_mmio;
  mmio_reg_e       data_reg;
  logic            reg_wr;

  logic [31:0]     ram_a_rdata;
  logic [31:0]     ram_b_rdata;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      num_q, num_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic             inst_mmio_q;
  logic             data_mmio_q;
  logic [31:0]      mmio_rdata_q, mmio_rdata_d;
  logic [31:0]      timer_rd;

  // Instruction wen/wdata and address byte-offset bits have no function here.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr, data_sram_addr[1:0]};

  assign inst_mmio = (inst_sram_addr[31:16] == MMIO_HI);
  assign data_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign data_reg  = data_mmio ? decode_offset(data_sram_addr[15:2]) : REG_NONE;
  assign reg_wr    = data_sram_en && data_mmio && (data_sram_wen != 4'b0000);

  sram_dp_bytewe #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk       (clk),
    .rst_n     (resetn),
    .a_en_i    (inst_sram_en && !inst_mmio),
    .a_addr_i  (inst_sram_addr[ADDR_W+1:2]),
    .a_rdata_o (ram_a_rdata),
    .b_en_i    (data_sram_en && !data_mmio),
    .b_wen_i   (data_sram_wen),
    .b_addr_i  (data_sram_addr[ADDR_W+1:2]),
    .b_wdata_i (data_sram_wdata),
    .b_rdata_o (ram_b_rdata)
  );

`ifdef SOC_SRAM_RESP_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // Timer counts every cycle; a write replaces the selected lanes instead of counting that cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (reg_wr && data_reg == REG_TIMER) begin
      timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
    end
  end

  // Timer state, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  // Register-file next state and the register-window read value (pre-write contents).
  always_comb begin
    led_d        = led_q;
    num_d        = num_q;
    mmio_rdata_d = '0;
    if (reg_wr && data_reg == REG_LED) begin
      for (int i = 0; i < LED_W / 8; i++) begin
        if (data_sram_wen[i]) led_d[i*8 +: 8] = data_sram_wdata[i*8 +: 8];
      end
    end
    if (reg_wr && data_reg == REG_NUM) begin
      num_d = merge_bytes(num_q, data_sram_wdata, data_sram_wen);
    end
    case (data_reg)
      REG_LED:    mmio_rdata_d = {{(32-LED_W){1'b0}}, led_q};
      REG_NUM:    mmio_rdata_d = num_q;
      REG_SWITCH: mmio_rdata_d = {{(32-SW_W){1'b0}}, sw_sync_q};
      REG_TIMER:  mmio_rdata_d = timer_rd;
      default:    mmio_rdata_d = '0;
    endcase
  end

  // Registers, switch synchronizer and per-port read-source tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= '0;
      num_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      inst_mmio_q  <= 1'b0;
      data_mmio_q  <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      if (inst_sram_en) inst_mmio_q <= inst_mmio;
      if (data_sram_en) begin
        data_mmio_q  <= data_mmio;
        mmio_rdata_q <= mmio_rdata_d;
      end
    end
  end

  // Instruction fetches from the register window read as zero.
  assign inst_sram_rdata = inst_mmio_q ? 32'd0 : ram_a_rdata;
  assign data_sram_rdata = data_mmio_q ? mmio_rdata_q : ram_b_rdata;
  assign led             = led_q;
  assign num             = num_q;

endmodule
